axibram_read_router: RTL and testbench
======================================

AXIBRAM_READ_ROUTER -- requirements
Module: axibram_read_router

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, default 10: AXI read-side word address width.
REQ-002 SHALL have parameter DEV_BITS, default 2: upper address bits selecting one of 2^DEV_BITS devices (4 by default).
REQ-003 SHALL have parameter TIMEOUT_BITS, default 8: width of the ready-wait counter; timeout limit is 2^TIMEOUT_BITS-1 cycles.
REQ-004 SHALL have parameter ERR_DATA, default 32'hdeadbeef: data returned for absent or timed-out devices.
REQ-005 SHALL have one clock and a synchronous, active-high reset; no other clock or reset exists.
REQ-006 SHALL have ports (name  direction  width  meaning):
- aclk  in  1  clock
- rst  in  1  synchronous active-high reset
- pre_araddr  in  ADDRESS_BITS  burst start address, valid with start_burst
- pre_arlen  in  4  burst length-1, valid with start_burst
- start_burst  in  1  one-cycle burst start strobe from the read channel
- dev_ready  out  1  ready returned to the read channel
- bram_ren  in  1  read enable from the read channel
- bram_regen  in  1  output-register enable from the read channel
- bram_raddr  in  ADDRESS_BITS  read address from the read channel
- bram_rdata  out  32  routed read data
- dev_en  in  2^DEV_BITS  device-present mask
- dev_ready_in  in  2^DEV_BITS  per-device ready
- dev_raddr  out  ADDRESS_BITS-DEV_BITS  shared low address bits
- dev_ren  out  2^DEV_BITS  per-device read enable
- dev_regen  out  2^DEV_BITS  per-device register enable
- dev_rdata  in  32*2^DEV_BITS  per-device data, device i at bits [32i+31:32i]
- sel  out  DEV_BITS  current burst device index
- timeout_err  out  1  sticky timeout flag
- timeout_dev  out  DEV_BITS  device of the first timeout
- clr_err  in  1  clears timeout_err

Function
REQ-007 SHALL latch sel <= pre_araddr[ADDRESS_BITS-1 -: DEV_BITS] and remaining <= pre_arlen+1 (5-bit) on start_burst.
REQ-008 SHALL implement FSM IDLE/BURST/TMO: IDLE->BURST on start_burst; BURST or TMO ->IDLE when bram_ren brings remaining to 0 without start_burst; any state ->BURST on start_burst (reload).
REQ-009 SHALL decrement remaining on each bram_ren in BURST/TMO; bram_ren in IDLE ignored.
REQ-010 On coincident start_burst and final bram_ren, SHALL route that bram_ren with the old sel, then apply the new sel/remaining the next cycle.
REQ-011 dev_ready SHALL be: 1 in IDLE; 1 in TMO; 1 in BURST if dev_en[sel]=0; else dev_ready_in[sel]; combinational from registered state.
REQ-012 dev_raddr SHALL equal bram_raddr[ADDRESS_BITS-DEV_BITS-1:0].
REQ-013 dev_ren[i] SHALL equal bram_ren && sel==i && dev_en[i] && state==BURST; all zero otherwise.
REQ-014 SHALL register sel_r2<=sel and sub_r2<=(TMO or !dev_en[sel]) on bram_ren; sel_o<=sel_r2, sub_o<=sub_r2 on bram_regen.
REQ-015 dev_regen[i] SHALL equal bram_regen && sel_r2==i && !sub_r2.
REQ-016 bram_rdata SHALL equal ERR_DATA when sub_o=1, else dev_rdata slice sel_o; zero added latency.
REQ-017 Wait counter SHALL increment each BURST cycle with dev_en[sel]=1 and dev_ready_in[sel]=0, clear otherwise or on start_burst, saturating.
REQ-018 When wait counter reaches 2^TIMEOUT_BITS-1, SHALL enter TMO next cycle; if timeout_err=0, set timeout_err=1 and timeout_dev=sel.
REQ-019 timeout_err SHALL hold until clr_err; a new timeout in the clr_err cycle wins (set).
REQ-020 Device index is DEV_BITS wide; out-of-mask devices are handled by dev_en, not by wrap.

Reset
REQ-021 On rst: state IDLE, sel=0, remaining=0, wait=0, sel_r2=sel_o=0, sub_r2=sub_o=0, timeout_err=0, timeout_dev=0; dev_ready=1, dev_ren=dev_regen=0, bram_rdata=dev_rdata[31:0].
REQ-022 rst mid-burst SHALL abort the burst; subsequent bram_ren before start_burst drives no dev_ren.

Verification
REQ-023 start_burst addr=0x2A0, len=3, all ready -> sel=2; 4 dev_ren[2] pulses; data from device 2 on each regen; IDLE after 4th ren.
REQ-024 Back-to-back: final ren of dev1 burst coincides with start_burst to dev3 -> that ren on dev_ren[1]; next ren on dev_ren[3].
REQ-025 dev_en[1]=0, burst to device 1, len=1 -> dev_ready=1, no dev_ren, two beats of 0xdeadbeef, timeout_err=0.
REQ-026 dev_ready_in[0]=0 for 300 cycles in BURST -> TMO after 255 cycles, timeout_err=1, timeout_dev=0, remaining beats 0xdeadbeef; clr_err -> 0.
REQ-027 rst asserted after 2 of 8 beats -> all outputs per REQ-021 next cycle; stray bram_ren -> dev_ren=0.

Source files
------------

// File: rtl/axibram_read_router.sv
// -----------------------------------------------------------------------------
// axibram_read_router
//
// Purpose:
//   Sits between an AXI read channel built around a single BRAM-style read
//   port and up to 2^DEV_BITS slave devices. The top DEV_BITS bits of the
//   burst start address select the target device for the whole burst.
//   Read enables are steered to that device. Output-register enables are
//   steered to the device that issued each beat. Read data is muxed back from
//   that device.
//
//   Missing devices (dev_en=0) and devices that stall longer than the timeout
//   limit are "substituted". They get no enables. Their beats return ERR_DATA
//   and dev_ready is forced high so that the read channel can drain the burst.
//
// Ports:
//   aclk, rst        clock and synchronous active-high reset
//   pre_araddr/len   burst start address and length-1, valid with start_burst
//   start_burst      one-cycle burst start strobe
//   dev_ready        ready returned to the read channel
//   bram_ren/regen   read enable and output-register enable from the channel
//   bram_raddr       read address from the channel
//   bram_rdata       routed read data (zero added latency after regen)
//   dev_en           device-present mask
//   dev_ready_in     per-device ready
//   dev_raddr        low address bits shared by all devices
//   dev_ren/regen    per-device read / register enables
//   dev_rdata        per-device data, device i at [32i+31:32i]
//   sel              device index of the current burst
//   timeout_err      sticky timeout flag, cleared by clr_err
//   timeout_dev      device that caused the first timeout
// -----------------------------------------------------------------------------
module axibram_read_router #(
  parameter int          ADDRESS_BITS = 10,
  parameter int          DEV_BITS     = 2,
  parameter int          TIMEOUT_BITS = 8,
  parameter logic [31:0] ERR_DATA     = 32'hdeadbeef
) (
  input  logic                               aclk,
  input  logic                               rst,
  input  logic [ADDRESS_BITS-1:0]            pre_araddr,
  input  logic [3:0]                         pre_arlen,
  input  logic                               start_burst,
  output logic                               dev_ready,
  input  logic                               bram_ren,
  input  logic                               bram_regen,
  input  logic [ADDRESS_BITS-1:0]            bram_raddr,
  output logic [31:0]                        bram_rdata,
  input  logic [(1<<DEV_BITS)-1:0]           dev_en,
  input  logic [(1<<DEV_BITS)-1:0]           dev_ready_in,
  output logic [ADDRESS_BITS-DEV_BITS-1:0]   dev_raddr,
  output logic [(1<<DEV_BITS)-1:0]           dev_ren,
  output logic [(1<<DEV_BITS)-1:0]           dev_regen,
  input  logic [32*(1<<DEV_BITS)-1:0]        dev_rdata,
  output logic [DEV_BITS-1:0]                sel,
  output logic                               timeout_err,
  output logic [DEV_BITS-1:0]                timeout_dev,
  input  logic                               clr_err
);

  localparam int NDEV     = 1 << DEV_BITS;
  localparam int LOW_BITS = ADDRESS_BITS - DEV_BITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_TMO   = 2'd2;

  localparam logic [TIMEOUT_BITS-1:0] WAIT_MAX  = {TIMEOUT_BITS{1'b1}};
  localparam logic [TIMEOUT_BITS-1:0] WAIT_ZERO = {TIMEOUT_BITS{1'b0}};
  localparam logic [TIMEOUT_BITS-1:0] WAIT_ONE  = {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};

  // Burst tracking state
  logic [1:0]              state_q, state_d;
  logic [DEV_BITS-1:0]     sel_q, sel_d;
  logic [4:0]              remaining_q, remaining_d;
  logic [TIMEOUT_BITS-1:0] wait_q, wait_d;

  // Read-data return pipeline: ren stage (_r2) then regen stage (_o)
  logic [DEV_BITS-1:0]     sel_r2_q;
  logic                    sub_r2_q;
  logic [DEV_BITS-1:0]     sel_o_q;
  logic                    sub_o_q;

  // Sticky error capture
  logic                    timeout_err_q, timeout_err_d;
  logic [DEV_BITS-1:0]     timeout_dev_q, timeout_dev_d;

  // Decoded conditions
  logic                    sel_en_s;
  logic                    sel_rdy_s;
  logic                    in_burst_s;
  logic                    active_s;
  logic                    last_beat_s;
  logic                    stall_s;
  logic                    tmo_fire_s;
  logic [31:0]             rdata_arr_s [NDEV];
  logic                    unused_s;

  // The device-select address bits and the low bits of the start address are
  // not used past decode.
  assign unused_s = ^{bram_raddr[ADDRESS_BITS-1:LOW_BITS], pre_araddr[LOW_BITS-1:0]};

  assign sel_en_s    = dev_en[sel_q];
  assign sel_rdy_s   = dev_ready_in[sel_q];
  assign in_burst_s  = (state_q == ST_BURST);
  assign active_s    = (state_q == ST_BURST) || (state_q == ST_TMO);
  // The final beat retires the burst. "<= 1" also covers a zero count, which
  // cannot occur in an active state.
  assign last_beat_s = active_s && bram_ren && (remaining_q <= 5'd1);
  // Only a present device that is holding ready low counts toward the timeout.
  assign stall_s     = in_burst_s && sel_en_s && !sel_rdy_s;
  assign tmo_fire_s  = in_burst_s && (wait_q == WAIT_MAX);

  for (genvar g = 0; g < NDEV; g++) begin : g_slice
    assign rdata_arr_s[g] = dev_rdata[32*g +: 32];
  end

  // Next-state logic for FSM, device select and beat counter
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    remaining_d = remaining_q;
    if (start_burst) begin
      // A new burst always reloads. A coincident final beat is still routed
      // with the old select, because the outputs decode the registered sel_q.
      state_d     = ST_BURST;
      sel_d       = pre_araddr[ADDRESS_BITS-1 -: DEV_BITS];
      remaining_d = {1'b0, pre_arlen} + 5'd1;
    end else begin
      if (active_s && bram_ren && (remaining_q != 5'd0)) begin
        remaining_d = remaining_q - 5'd1;
      end else begin
        remaining_d = remaining_q;
      end
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_BURST: begin
          if (last_beat_s) begin
            state_d = ST_IDLE;
          end else if (tmo_fire_s) begin
            state_d = ST_TMO;
          end else begin
            state_d = ST_BURST;
          end
        end
        ST_TMO: begin
          if (last_beat_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_TMO;
          end
        end
        default: begin
          // Recover from an unreachable encoding.
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Ready-wait counter: counts stalled BURST cycles and saturates at the limit
  always_comb begin
    wait_d = wait_q;
    if (start_burst) begin
      wait_d = WAIT_ZERO;
    end else if (stall_s) begin
      if (wait_q == WAIT_MAX) begin
        wait_d = WAIT_MAX;
      end else begin
        wait_d = wait_q + WAIT_ONE;
      end
    end else begin
      wait_d = WAIT_ZERO;
    end
  end

  // Sticky timeout flag. A timeout in the same cycle as clr_err wins.
  always_comb begin
    timeout_err_d = timeout_err_q;
    timeout_dev_d = timeout_dev_q;
    if (tmo_fire_s && (!timeout_err_q || clr_err)) begin
      timeout_err_d = 1'b1;
      timeout_dev_d = sel_q;
    end else if (clr_err) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  // Control and error state registers
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sel_q         <= {DEV_BITS{1'b0}};
      remaining_q   <= 5'd0;
      wait_q        <= WAIT_ZERO;
      timeout_err_q <= 1'b0;
      timeout_dev_q <= {DEV_BITS{1'b0}};
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      remaining_q   <= remaining_d;
      wait_q        <= wait_d;
      timeout_err_q <= timeout_err_d;
      timeout_dev_q <= timeout_dev_d;
    end
  end

  // Return-path pipeline. It follows the BRAM read (ren) and output-register
  // (regen) stages, so each beat's data is muxed from the device that issued
  // the beat.
  always_ff @(posedge aclk) begin
    if (rst) begin
      sel_r2_q <= {DEV_BITS{1'b0}};
      sub_r2_q <= 1'b0;
      sel_o_q  <= {DEV_BITS{1'b0}};
      sub_o_q  <= 1'b0;
    end else begin
      if (bram_ren) begin
        sel_r2_q <= sel_q;
        sub_r2_q <= (state_q == ST_TMO) || !sel_en_s;
      end
      if (bram_regen) begin
        sel_o_q <= sel_r2_q;
        sub_o_q <= sub_r2_q;
      end
    end
  end

  // Ready back to the read channel. It is forced high whenever the beat will
  // be substituted.
  always_comb begin
    dev_ready = 1'b1;
    case (state_q)
      ST_IDLE:  dev_ready = 1'b1;
      ST_BURST: dev_ready = !sel_en_s || sel_rdy_s;
      ST_TMO:   dev_ready = 1'b1;
      default:  dev_ready = 1'b1;
    endcase
  end

  // Read-enable steering, only to a present device during a live burst
  always_comb begin
    dev_ren = {NDEV{1'b0}};
    if (bram_ren && in_burst_s && sel_en_s) begin
      dev_ren[sel_q] = 1'b1;
    end else begin
      dev_ren = {NDEV{1'b0}};
    end
  end

  // Register-enable steering to the device that issued the pending beat
  always_comb begin
    dev_regen = {NDEV{1'b0}};
    if (bram_regen && !sub_r2_q) begin
      dev_regen[sel_r2_q] = 1'b1;
    end else begin
      dev_regen = {NDEV{1'b0}};
    end
  end

  // Data return mux
  always_comb begin
    bram_rdata = rdata_arr_s[sel_o_q];
    if (sub_o_q) begin
      bram_rdata = ERR_DATA;
    end else begin
      bram_rdata = rdata_arr_s[sel_o_q];
    end
  end

  assign dev_raddr   = bram_raddr[LOW_BITS-1:0];
  assign sel         = sel_q;
  assign timeout_err = timeout_err_q;
  assign timeout_dev = timeout_dev_q;

endmodule

// File: tb/tb_axibram_read_router.sv
module tb_axibram_read_router;

  localparam logic [31:0] ERR = 32'hdeadbeef;

  logic         aclk;
  logic         rst;
  logic [9:0]   pre_araddr;
  logic [3:0]   pre_arlen;
  logic         start_burst;
  logic         dev_ready;
  logic         bram_ren;
  logic         bram_regen;
  logic [9:0]   bram_raddr;
  logic [31:0]  bram_rdata;
  logic [3:0]   dev_en;
  logic [3:0]   dev_ready_in;
  logic [7:0]   dev_raddr;
  logic [3:0]   dev_ren;
  logic [3:0]   dev_regen;
  logic [127:0] dev_rdata;
  logic [1:0]   sel;
  logic         timeout_err;
  logic [1:0]   timeout_dev;
  logic         clr_err;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] words [4];

  axibram_read_router dut (
    .aclk(aclk), .rst(rst), .pre_araddr(pre_araddr), .pre_arlen(pre_arlen),
    .start_burst(start_burst), .dev_ready(dev_ready), .bram_ren(bram_ren),
    .bram_regen(bram_regen), .bram_raddr(bram_raddr), .bram_rdata(bram_rdata),
    .dev_en(dev_en), .dev_ready_in(dev_ready_in), .dev_raddr(dev_raddr),
    .dev_ren(dev_ren), .dev_regen(dev_regen), .dev_rdata(dev_rdata), .sel(sel),
    .timeout_err(timeout_err), .timeout_dev(timeout_dev), .clr_err(clr_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- reference model (spec-level rules) ----------------
  // Target device: the top two bits of a 10-bit start address.
  function automatic int dev_of(input logic [9:0] addr);
    return int'(addr) / 256;
  endfunction

  // A beat reaches the device only if the device is present and not timed out.
  function automatic logic [3:0] exp_ren(input int d, input logic [3:0] en, input bit tmo);
    logic [3:0] r;
    r = 4'b0000;
    if (!tmo && en[d]) r[d] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] exp_data(input int d, input logic [3:0] en, input bit tmo);
    return (tmo || !en[d]) ? ERR : words[d];
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic set_words();
    for (int i = 0; i < 4; i++) begin
      words[i] = $urandom;
      dev_rdata[32*i +: 32] = words[i];
    end
  endtask

  task automatic apply_reset();
    @(posedge aclk); #1 rst = 1'b1;
    @(posedge aclk); #1 rst = 1'b0;
  endtask

  task automatic start(input logic [9:0] addr, input logic [3:0] len);
    @(posedge aclk); #1;
    start_burst = 1'b1; pre_araddr = addr; pre_arlen = len;
    @(posedge aclk); #1;
    start_burst = 1'b0;
  endtask

  // One beat: ren cycle, regen cycle, then data sampled after the regen edge.
  task automatic beat(output logic rdy_o, output logic [3:0] ren_o, output logic [7:0] raddr_o,
                      output logic [7:0] raddr_exp, output logic [3:0] regen_o,
                      output logic [31:0] data_o);
    logic [9:0] a;
    a = 10'($urandom);
    @(posedge aclk); #1;
    rdy_o = dev_ready;
    bram_ren = 1'b1; bram_raddr = a;
    #1;
    ren_o = dev_ren; raddr_o = dev_raddr; raddr_exp = a[7:0];
    @(posedge aclk); #1;
    bram_ren = 1'b0; bram_regen = 1'b1;
    #1 regen_o = dev_regen;
    @(posedge aclk); #1;
    bram_regen = 1'b0;
    #1 data_o = bram_rdata;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_words();
    apply_reset();
    #1;
    total_cnt++; if (dev_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", dev_ready); else pass_cnt++;
    total_cnt++; if (sel !== 2'd0) $display("FAIL reset_sel got %0d want 0", sel); else pass_cnt++;
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL reset_err got %b want 0", timeout_err); else pass_cnt++;
    total_cnt++; if (timeout_dev !== 2'd0) $display("FAIL reset_tdev got %0d want 0", timeout_dev); else pass_cnt++;
    total_cnt++; if (dev_regen !== 4'b0) $display("FAIL reset_regen got %b want 0", dev_regen); else pass_cnt++;
    total_cnt++; if (bram_rdata !== words[0]) $display("FAIL reset_rdata got %h want %h", bram_rdata, words[0]); else pass_cnt++;
    bram_ren = 1'b1; #1;
    total_cnt++; if (dev_ren !== 4'b0) $display("FAIL reset_stray_ren got %b want 0", dev_ren); else pass_cnt++;
    bram_ren = 1'b0;
  endtask

  task automatic test_basic_burst();
    logic rdy; logic [3:0] ren, rg; logic [7:0] ra, rae; logic [31:0] dat;
    logic [9:0] addr;
    int d;
    addr = 10'h2A0; d = dev_of(addr);
    dev_en = 4'hF; dev_ready_in = 4'hF; set_words();
    start(addr, 4'd3);
    total_cnt++; if (sel !== 2'(d)) $display("FAIL basic_sel got %0d want %0d", sel, d); else pass_cnt++;
    for (int b = 0; b < 4; b++) begin
      beat(rdy, ren, ra, rae, rg, dat);
      total_cnt++; if (rdy !== 1'b1) $display("FAIL basic_ready beat %0d got %b want 1", b, rdy); else pass_cnt++;
      total_cnt++; if (ren !== exp_ren(d, dev_en, 1'b0)) $display("FAIL basic_ren beat %0d got %b want %b", b, ren, exp_ren(d, dev_en, 1'b0)); else pass_cnt++;
      total_cnt++; if (ra !== rae) $display("FAIL basic_raddr beat %0d got %h want %h", b, ra, rae); else pass_cnt++;
      total_cnt++; if (rg !== exp_ren(d, dev_en, 1'b0)) $display("FAIL basic_regen beat %0d got %b want %b", b, rg, exp_ren(d, dev_en, 1'b0)); else pass_cnt++;
      total_cnt++; if (dat !== exp_data(d, dev_en, 1'b0)) $display("FAIL basic_data beat %0d got %h want %h", b, dat, exp_data(d, dev_en, 1'b0)); else pass_cnt++;
    end
    // Burst is over: a fifth read must not reach any device.
    beat(rdy, ren, ra, rae, rg, dat);
    total_cnt++; if (ren !== 4'b0) $display("FAIL basic_idle_ren got %b want 0", ren); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic rdy; logic [3:0] ren, rg; logic [7:0] ra, rae; logic [31:0] dat;
    int len;
    len = $urandom_range(1, 3);
    dev_en = 4'hF; dev_ready_in = 4'hF; set_words();
    start({2'd1, 8'($urandom)}, 4'(len));
    for (int b = 0; b < len; b++) begin
      beat(rdy, ren, ra, rae, rg, dat);
      total_cnt++; if (ren !== 4'b0010) $display("FAIL b2b_ren1 beat %0d got %b want 0010", b, ren); else pass_cnt++;
    end
    // The final dev1 beat coincides with a new burst to dev3.
    @(posedge aclk); #1;
    bram_ren = 1'b1; bram_raddr = 10'($urandom);
    start_burst = 1'b1; pre_araddr = {2'd3, 8'($urandom)}; pre_arlen = 4'd1;
    #1;
    total_cnt++; if (dev_ren !== 4'b0010) $display("FAIL b2b_last_ren got %b want 0010", dev_ren); else pass_cnt++;
    @(posedge aclk); #1;
    bram_ren = 1'b0; start_burst = 1'b0; bram_regen = 1'b1;
    #1;
    total_cnt++; if (dev_regen !== 4'b0010) $display("FAIL b2b_last_regen got %b want 0010", dev_regen); else pass_cnt++;
    @(posedge aclk); #1;
    bram_regen = 1'b0;
    #1;
    total_cnt++; if (bram_rdata !== words[1]) $display("FAIL b2b_last_data got %h want %h", bram_rdata, words[1]); else pass_cnt++;
    total_cnt++; if (sel !== 2'd3) $display("FAIL b2b_sel got %0d want 3", sel); else pass_cnt++;
    for (int b = 0; b < 2; b++) begin
      beat(rdy, ren, ra, rae, rg, dat);
      total_cnt++; if (ren !== 4'b1000) $display("FAIL b2b_ren3 beat %0d got %b want 1000", b, ren); else pass_cnt++;
      total_cnt++; if (dat !== words[3]) $display("FAIL b2b_data3 beat %0d got %h want %h", b, dat, words[3]); else pass_cnt++;
    end
    beat(rdy, ren, ra, rae, rg, dat);
    total_cnt++; if (ren !== 4'b0) $display("FAIL b2b_idle_ren got %b want 0", ren); else pass_cnt++;
  endtask

  task automatic test_absent_device();
    logic rdy; logic [3:0] ren, rg; logic [7:0] ra, rae; logic [31:0] dat;
    dev_en = 4'b1101; dev_ready_in = 4'b0000; set_words();
    start({2'd1, 8'($urandom)}, 4'd1);
    #1;
    total_cnt++; if (dev_ready !== 1'b1) $display("FAIL absent_ready got %b want 1", dev_ready); else pass_cnt++;
    for (int b = 0; b < 2; b++) begin
      beat(rdy, ren, ra, rae, rg, dat);
      total_cnt++; if (ren !== 4'b0) $display("FAIL absent_ren beat %0d got %b want 0", b, ren); else pass_cnt++;
      total_cnt++; if (rg !== 4'b0) $display("FAIL absent_regen beat %0d got %b want 0", b, rg); else pass_cnt++;
      total_cnt++; if (dat !== ERR) $display("FAIL absent_data beat %0d got %h want %h", b, dat, ERR); else pass_cnt++;
    end
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL absent_err got %b want 0", timeout_err); else pass_cnt++;
    dev_ready_in = 4'hF;
  endtask

  task automatic test_timeout();
    logic rdy; logic [3:0] ren, rg; logic [7:0] ra, rae; logic [31:0] dat;
    dev_en = 4'hF; dev_ready_in = 4'b1110; set_words();
    start({2'd0, 8'($urandom)}, 4'd3);
    repeat (250) @(posedge aclk);
    #1;
    total_cnt++; if (dev_ready !== 1'b0) $display("FAIL tmo_stall_ready got %b want 0", dev_ready); else pass_cnt++;
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL tmo_early_err got %b want 0", timeout_err); else pass_cnt++;
    repeat (50) @(posedge aclk);
    #1;
    total_cnt++; if (timeout_err !== 1'b1) $display("FAIL tmo_err got %b want 1", timeout_err); else pass_cnt++;
    total_cnt++; if (timeout_dev !== 2'd0) $display("FAIL tmo_dev got %0d want 0", timeout_dev); else pass_cnt++;
    total_cnt++; if (dev_ready !== 1'b1) $display("FAIL tmo_ready got %b want 1", dev_ready); else pass_cnt++;
    for (int b = 0; b < 4; b++) begin
      beat(rdy, ren, ra, rae, rg, dat);
      total_cnt++; if (ren !== exp_ren(0, dev_en, 1'b1)) $display("FAIL tmo_ren beat %0d got %b want 0", b, ren); else pass_cnt++;
      total_cnt++; if (dat !== exp_data(0, dev_en, 1'b1)) $display("FAIL tmo_data beat %0d got %h want %h", b, dat, ERR); else pass_cnt++;
    end
    total_cnt++; if (timeout_err !== 1'b1) $display("FAIL tmo_sticky got %b want 1", timeout_err); else pass_cnt++;
    @(posedge aclk); #1 clr_err = 1'b1;
    @(posedge aclk); #1 clr_err = 1'b0;
    #1;
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL tmo_clr got %b want 0", timeout_err); else pass_cnt++;
    dev_ready_in = 4'hF;
  endtask

  task automatic test_reset_mid_burst();
    logic rdy; logic [3:0] ren, rg; logic [7:0] ra, rae; logic [31:0] dat;
    int d;
    d = $urandom_range(1, 3);
    dev_en = 4'hF; dev_ready_in = 4'hF; set_words();
    start({2'(d), 8'($urandom)}, 4'd7);
    for (int b = 0; b < 2; b++) begin
      beat(rdy, ren, ra, rae, rg, dat);
      total_cnt++; if (ren !== exp_ren(d, dev_en, 1'b0)) $display("FAIL rstmid_ren beat %0d got %b want %b", b, ren, exp_ren(d, dev_en, 1'b0)); else pass_cnt++;
    end
    @(posedge aclk); #1 rst = 1'b1;
    @(posedge aclk); #2;
    total_cnt++; if (sel !== 2'd0) $display("FAIL rstmid_sel got %0d want 0", sel); else pass_cnt++;
    total_cnt++; if (dev_ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", dev_ready); else pass_cnt++;
    total_cnt++; if (dev_regen !== 4'b0) $display("FAIL rstmid_regen got %b want 0", dev_regen); else pass_cnt++;
    total_cnt++; if (bram_rdata !== words[0]) $display("FAIL rstmid_rdata got %h want %h", bram_rdata, words[0]); else pass_cnt++;
    rst = 1'b0;
    beat(rdy, ren, ra, rae, rg, dat);
    total_cnt++; if (ren !== 4'b0) $display("FAIL rstmid_stray_ren got %b want 0", ren); else pass_cnt++;
  endtask

  task automatic test_random_bursts();
    logic rdy; logic [3:0] ren, rg; logic [7:0] ra, rae; logic [31:0] dat;
    logic [9:0] addr;
    int d, len;
    dev_ready_in = 4'hF;
    for (int n = 0; n < 20; n++) begin
      set_words();
      dev_en = 4'($urandom);
      addr = 10'($urandom); d = dev_of(addr);
      len = $urandom_range(0, 3);
      start(addr, 4'(len));
      total_cnt++; if (sel !== 2'(d)) $display("FAIL rnd_sel burst %0d got %0d want %0d", n, sel, d); else pass_cnt++;
      for (int b = 0; b <= len; b++) begin
        beat(rdy, ren, ra, rae, rg, dat);
        total_cnt++; if (rdy !== 1'b1) $display("FAIL rnd_ready burst %0d got %b want 1", n, rdy); else pass_cnt++;
        total_cnt++; if (ren !== exp_ren(d, dev_en, 1'b0)) $display("FAIL rnd_ren burst %0d beat %0d got %b want %b", n, b, ren, exp_ren(d, dev_en, 1'b0)); else pass_cnt++;
        total_cnt++; if (ra !== rae) $display("FAIL rnd_raddr burst %0d got %h want %h", n, ra, rae); else pass_cnt++;
        total_cnt++; if (dat !== exp_data(d, dev_en, 1'b0)) $display("FAIL rnd_data burst %0d beat %0d got %h want %h", n, b, dat, exp_data(d, dev_en, 1'b0)); else pass_cnt++;
      end
      beat(rdy, ren, ra, rae, rg, dat);
      total_cnt++; if (ren !== 4'b0) $display("FAIL rnd_idle_ren burst %0d got %b want 0", n, ren); else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; pre_araddr = 10'd0; pre_arlen = 4'd0; start_burst = 1'b0;
    bram_ren = 1'b0; bram_regen = 1'b0; bram_raddr = 10'd0;
    dev_en = 4'hF; dev_ready_in = 4'hF; dev_rdata = 128'd0; clr_err = 1'b0;
    test_reset();
    test_basic_burst();
    test_back_to_back();
    test_absent_device();
    test_timeout();
    test_reset_mid_burst();
    test_random_bursts();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
